mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified instruction/data memory of the multicycle RISC-V core between the core (port 0) and a second bus master such as a program loader or DMA (port 1). The arbiter selects one port per cycle. It forwards that port's address, write data and write enable to the memory, and returns registered read data with a one-cycle-late valid strobe. It sits between the core's memory-address mux and the memory instance. The core must hold its multicycle FSM while its grant is low.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_pick2.sv | 13 +
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int   PORT_CORE    = 0;
    localparam int   PORT_EXT     = 1;
    localparam int   MAX_LOCK_DEF = 8;
    // Reset value of last: port 1 "most recent" so the core wins the first contention.
    localparam logic LAST_RESET   = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - 2-way round-robin picker; a tie goes to the port not granted last
module rr_pick2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_gnt0,
    output logic o_gnt1
);

    assign o_gnt0 = i_req0 & (~i_req1 | i_last);
    assign o_gnt1 = i_req1 & (~i_req0 | ~i_last);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the unified I/D memory between the core (port 0) and an external master (port 1)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    localparam logic [8:0] LP_MAX = 9'(MAX_LOCK);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    w_cnt_nxt;
    logic [DW-1:0] r_rdata;
    logic          r_rvalid0;
    logic          r_rvalid1;

    logic          w_pick0;
    logic          w_pick1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_cont;
    logic          w_g_lock;
    logic          w_oth_req;
    logic          w_oth_lock;
    logic [8:0]    w_beats;

    rr_pick2 u_pick (
        .i_req0 (m0_req),
        .i_req1 (m1_req),
        .i_last (r_last),
        .o_gnt0 (w_pick0),
        .o_gnt1 (w_pick1)
    );

    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_cont      = 1'b0;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_last_nxt  = r_last;

        // An owner that stops requesting falls through to plain arbitration this cycle.
        if (r_state == OWN0 && m0_req) begin
            w_gnt0 = 1'b1;
            w_cont = 1'b1;
        end else if (r_state == OWN1 && m1_req) begin
            w_gnt1 = 1'b1;
            w_cont = 1'b1;
        end else begin
            w_gnt0 = w_pick0;
            w_gnt1 = w_pick1;
        end

        w_g_lock   = w_gnt1 ? m1_lock : m0_lock;
        w_oth_req  = w_gnt1 ? m0_req  : m1_req;
        w_oth_lock = w_gnt1 ? m0_lock : m1_lock;
        // Beats are only counted while the other port is waiting.
        w_beats    = (w_cont ? {1'b0, r_cnt} : 9'd0) + {8'd0, w_oth_req};

        if (w_gnt0 || w_gnt1) begin
            w_last_nxt = w_gnt1;
            if (w_g_lock && w_beats < LP_MAX) begin
                w_state_nxt = w_gnt1 ? OWN1 : OWN0;
                w_cnt_nxt   = w_beats[7:0];
            end else if ((w_cont || w_g_lock) && w_oth_req && w_oth_lock) begin
                w_state_nxt = w_gnt1 ? OWN0 : OWN1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= LAST_RESET;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rvalid0 <= w_gnt0 & ~m0_we;
            r_rvalid1 <= w_gnt1 & ~m1_we;
            if ((w_gnt0 & ~m0_we) | (w_gnt1 & ~m1_we)) begin
                r_rdata <= mem_rd;
            end
        end
    end

    assign m0_gnt    = w_gnt0 & ~rst;
    assign m1_gnt    = w_gnt1 & ~rst;
    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_rdata  = r_rdata;
    assign m1_rdata  = r_rdata;

    assign mem_a  = m1_gnt ? m1_addr  : m0_addr;
    assign mem_wd = m1_gnt ? m1_wdata : m0_wdata;
    assign mem_we = (m0_gnt & m0_we) | (m1_gnt & m1_we);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LOCK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 4) return 32'hDEADBEEF;
        return 32'hA5000000 ^ (32'(idx) * 32'h00010101);
    endfunction

    logic [31:0] tb_mem [256];
    bit          wr_flag [256];
    assign mem_rd = wr_flag[mem_a[9:2]] ? tb_mem[mem_a[9:2]] : init_val(int'(mem_a[9:2]));
    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_a[9:2]]  <= mem_wd;
            wr_flag[mem_a[9:2]] <= 1'b1;
        end
    end

    logic [31:0] model [int];
    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int idx = int'(a[9:2]);
        return model.exists(idx) ? model[idx] : init_val(idx);
    endfunction

    typedef struct {
        logic        rst, r0, we0, lk0;
        logic [31:0] a0, d0;
        logic        r1, we1, lk1;
        logic [31:0] a1, d1;
        logic        eg0, eg1;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic exp_rv0 = 1'b0;
    logic exp_rv1 = 1'b0;

    function automatic vec_t mk(input logic rs, input logic r0, input logic we0, input logic lk0,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic we1, input logic lk1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic eg0, input logic eg1);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else passed++;
    endtask

    task automatic step(input vec_t v, input string nm);
        rsp_t r;
        logic exp_we;
        @(negedge clk);
        rst = v.rst;
        m0_req = v.r0; m0_we = v.we0; m0_lock = v.lk0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_we = v.we1; m1_lock = v.lk1; m1_addr = v.a1; m1_wdata = v.d1;
        #1;
        chk({nm, " rvalid0"}, 32'(m0_rvalid), 32'(exp_rv0));
        chk({nm, " rvalid1"}, 32'(m1_rvalid), 32'(exp_rv1));
        if ((exp_rv0 || exp_rv1) && sb.size() > 0) begin
            r = sb.pop_front();
            chk({nm, " rdata"}, r.port ? m1_rdata : m0_rdata, r.data);
        end
        exp_we = !v.rst && ((v.eg0 && v.we0) || (v.eg1 && v.we1));
        chk({nm, " gnt0"}, 32'(m0_gnt), 32'(v.eg0));
        chk({nm, " gnt1"}, 32'(m1_gnt), 32'(v.eg1));
        chk({nm, " mem_we"}, 32'(mem_we), 32'(exp_we));
        chk({nm, " mem_a"}, mem_a, v.eg1 ? v.a1 : v.a0);
        if (exp_we) chk({nm, " mem_wd"}, mem_wd, v.eg1 ? v.d1 : v.d0);

        exp_rv0 = !v.rst && v.eg0 && !v.we0;
        exp_rv1 = !v.rst && v.eg1 && !v.we1;
        if (exp_rv0) sb.push_back('{port: 1'b0, data: exp_rd(v.a0)});
        if (exp_rv1) sb.push_back('{port: 1'b1, data: exp_rd(v.a1)});
        if (exp_we) model[int'(v.eg1 ? v.a1[9:2] : v.a0[9:2])] = v.eg1 ? v.d1 : v.d0;
        if (v.rst) sb.delete();
    endtask

    vec_t  tbl[$];
    string tnm[$];

    initial begin
        step(mk(1, 1,0,0,32'h10,0, 1,0,0,32'h14,0, 0,0), "reset0");
        step(mk(1, 1,1,0,32'h10,5, 1,1,0,32'h14,6, 0,0), "reset1");
        chk("reset rdata0", m0_rdata, 32'h0);
        chk("reset rdata1", m1_rdata, 32'h0);

        tbl.push_back(mk(0, 1,0,0,32'h20,0,          1,0,0,32'h24,0,          1,0)); tnm.push_back("cont_p0");
        tbl.push_back(mk(0, 1,0,0,32'h28,0,          1,0,0,32'h24,0,          0,1)); tnm.push_back("cont_p1");
        tbl.push_back(mk(0, 1,0,0,32'h28,0,          1,0,0,32'h2C,0,          1,0)); tnm.push_back("alt_p0");
        tbl.push_back(mk(0, 0,0,0,32'h0,0,           1,0,0,32'h2C,0,          0,1)); tnm.push_back("alt_p1");
        tbl.push_back(mk(0, 1,0,0,32'h10,0,          0,0,0,32'h0,0,           1,0)); tnm.push_back("single_rd");
        tbl.push_back(mk(0, 0,0,0,32'h0,0,           0,0,0,32'h0,0,           0,0)); tnm.push_back("idle0");
        tbl.push_back(mk(0, 0,0,0,32'h0,0,           1,1,0,32'h40,32'h12345678, 0,1)); tnm.push_back("p1_wr");
        tbl.push_back(mk(0, 1,0,0,32'h40,0,          0,0,0,32'h0,0,           1,0)); tnm.push_back("p0_rd_back");
        tbl.push_back(mk(0, 0,0,0,32'h0,0,           0,0,0,32'h0,0,           0,0)); tnm.push_back("idle1");
        tbl.push_back(mk(0, 1,1,0,32'h50,32'hCAFEF00D, 1,1,0,32'h54,32'h0BADC0DE, 0,1)); tnm.push_back("wr_cont_p1");
        tbl.push_back(mk(0, 1,1,0,32'h50,32'hCAFEF00D, 0,0,0,32'h0,0,          1,0)); tnm.push_back("wr_cont_p0");
        tbl.push_back(mk(0, 0,0,0,32'h0,0,           1,0,0,32'h50,0,          0,1)); tnm.push_back("p1_rd50");
        tbl.push_back(mk(0, 1,0,0,32'h54,0,          0,0,0,32'h0,0,           1,0)); tnm.push_back("p0_rd54");
        tbl.push_back(mk(0, 0,0,0,32'h0,0,           0,0,0,32'h0,0,           0,0)); tnm.push_back("idle2");
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], tnm[i]);

        // Port 1 locked against a waiting port 0: LOCK beats, then a forced handover.
        for (int i = 0; i < LOCK + 2; i++)
            step(mk(0, 1,0,0,32'h100 + 32'(4*i),0, 1,0,1,32'h200 + 32'(4*i),0,
                    (i == LOCK), (i != LOCK)), $sformatf("starve%0d", i));
        step(mk(0, 0,0,0,32'h0,0, 0,0,0,32'h0,0, 0,0), "idle3");

        for (int i = 0; i < 20; i++)
            step(mk(0, 1,0,(i < 19),32'h300 + 32'(4*i),0, 0,0,0,32'h0,0, 1,0),
                 $sformatf("uncont%0d", i));
        step(mk(0, 0,0,0,32'h0,0, 0,0,0,32'h0,0, 0,0), "idle4");

        step(mk(0, 0,0,0,32'h0,0, 1,0,1,32'h380,0, 0,1), "burst1");
        step(mk(0, 0,0,0,32'h0,0, 1,0,1,32'h384,0, 0,1), "burst2");
        step(mk(1, 0,0,0,32'h0,0, 1,0,1,32'h388,0, 0,0), "burst3_rst");
        step(mk(1, 1,0,0,32'h38C,0, 1,1,1,32'h388,7, 0,0), "after_rst");
        step(mk(0, 1,0,0,32'h3A0,0, 1,0,0,32'h3A4,0, 1,0), "post_rst_p0");
        step(mk(0, 0,0,0,32'h0,0,   1,0,0,32'h3A4,0, 0,1), "post_rst_p1");
        step(mk(0, 0,0,0,32'h0,0,   0,0,0,32'h0,0,   0,0), "idle5");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
